// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg
//   Shared Z80 bus-monitor definitions: opcode constants for the prefix
//   decoder and the prefix-state type. Also used by the PIO/SIO monitors.
package z80_bus_pkg;

   localparam logic [7:0] OP_ED   = 8'hED;
   localparam logic [7:0] OP_CB   = 8'hCB;
   localparam logic [7:0] OP_DD   = 8'hDD;
   localparam logic [7:0] OP_FD   = 8'hFD;
   localparam logic [7:0] OP_RETI = 8'h4D;
   localparam logic [7:0] OP_RETN = 8'h45;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ED   = 2'd1,
      ST_CB   = 2'd2,
      ST_IDX  = 2'd3
   } z80pfx_t;

endpackage

// File: rtl/z80_reti.sv
// z80_reti
//   Z80 bus monitor that derives the interrupt-acknowledge and RETI/RETN
//   signals needed by the daisy-chained CTC/PIO/SIO peripherals. Every M1
//   opcode fetch is decoded through a prefix state machine so that operand
//   bytes and CB/DD/FD sequences never produce a false RETI.
//
// Ports
//   I_CLK      system clock
//   I_RESET    synchronous active-high reset (acts regardless of I_CLKEN)
//   I_CLKEN    CPU clock enable; all sampling and updates qualified by it
//   I_M1_n     CPU M1 (active low)
//   I_MREQ_n   CPU MREQ (active low)
//   I_IORQ_n   CPU IORQ (active low)
//   I_RD_n     CPU RD (active low)
//   I_D        CPU data-in bus
//   O_SPM1     interrupt-acknowledge cycle in progress (registered)
//   O_RETI     RETI executed, one I_CLKEN period wide
//   O_RETN     RETN executed, one I_CLKEN period wide (0 if ENABLE_RETN=0)
module z80_reti
   import z80_bus_pkg::*;
#(
   parameter int unsigned ENABLE_RETN = 1
) (
   input  logic       I_CLK,
   input  logic       I_RESET,
   input  logic       I_CLKEN,
   input  logic       I_M1_n,
   input  logic       I_MREQ_n,
   input  logic       I_IORQ_n,
   input  logic       I_RD_n,
   input  logic [7:0] I_D,
   output logic       O_SPM1,
   output logic       O_RETI,
   output logic       O_RETN
);

   logic       ack;
   logic       fetch;
   logic       fetch_end;
   logic       retn_hit;

   logic       fetch_q;
   logic       spm1_q;
   logic       reti_q;
   logic       retn_q;
   logic [7:0] opcode_q;
   z80pfx_t    state_q;

   // Acknowledge wins over fetch: M1+IORQ is never an opcode read.
   assign ack   = ~I_M1_n & ~I_IORQ_n;
   assign fetch = ~I_M1_n & ~I_MREQ_n & ~I_RD_n & ~ack;

   // Decode on the first enable after the fetch strobe drops, so the byte
   // held in opcode_q is the last sample of a possibly WAIT-stretched read.
   assign fetch_end = fetch_q & ~fetch;

   // RETN decode disappears entirely when the feature is disabled.
   assign retn_hit = (ENABLE_RETN != 0) && (opcode_q == OP_RETN);

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         fetch_q  <= 1'b0;
         spm1_q   <= 1'b0;
         reti_q   <= 1'b0;
         retn_q   <= 1'b0;
         opcode_q <= 8'h00;
         state_q  <= ST_IDLE;
      end else if (I_CLKEN) begin
         spm1_q  <= ack;
         fetch_q <= fetch;
         // Pulses last exactly one enable period.
         reti_q  <= 1'b0;
         retn_q  <= 1'b0;

         if (fetch) begin
            opcode_q <= I_D;
         end

         // An acknowledge cycle abandons any partially decoded prefix; it
         // also suppresses a fetch end on the same enable, so a pulse can
         // never coincide with O_SPM1.
         if (ack) begin
            state_q <= ST_IDLE;
         end else if (fetch_end) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (opcode_q == OP_ED) begin
                     state_q <= ST_ED;
                  end else if (opcode_q == OP_CB) begin
                     state_q <= ST_CB;
                  end else if ((opcode_q == OP_DD) || (opcode_q == OP_FD)) begin
                     state_q <= ST_IDX;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
               ST_ED: begin
                  state_q <= ST_IDLE;
                  if (opcode_q == OP_RETI) begin
                     reti_q <= 1'b1;
                  end else if (retn_hit) begin
                     retn_q <= 1'b1;
                  end
               end
               // The byte after CB is a bit opcode, even if it reads as ED.
               ST_CB: begin
                  state_q <= ST_IDLE;
               end
               ST_IDX: begin
                  if ((opcode_q == OP_DD) || (opcode_q == OP_FD)) begin
                     state_q <= ST_IDX;
                  end else if (opcode_q == OP_ED) begin
                     state_q <= ST_ED;
                  end else begin
                     // Includes DD/FD CB: displacement and opcode follow as
                     // non-M1 reads, so the next M1 starts a new instruction.
                     state_q <= ST_IDLE;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign O_SPM1 = spm1_q;
   assign O_RETI = reti_q;
   assign O_RETN = retn_q;

endmodule

// File: tb/tb_z80_reti.sv
// tb_z80_reti
//   Bench for z80_reti: a bus-functional Z80 drives M1 fetches, non-M1 reads
//   and acknowledge cycles. An instruction-level model parses the stream of
//   M1 opcodes into whole instructions to predict RETI/RETN; one compare
//   process checks all outputs every clock, and directed tests add
//   hand-computed literal expectations (pulse counts, widths, SPM1 timing).
module tb_z80_reti;
   import z80_bus_pkg::*;

   localparam int ENABLE_RETN = 1;

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       clken  = 1'b0;
   logic       m1_n   = 1'b1;
   logic       mreq_n = 1'b1;
   logic       iorq_n = 1'b1;
   logic       rd_n   = 1'b1;
   logic [7:0] d      = 8'h00;
   logic       spm1;
   logic       reti;
   logic       retn;

   int  ph   = 0;
   bit  fast = 1'b0;

   int  n_chk  = 0;
   int  n_fail = 0;

   z80_reti #(.ENABLE_RETN(ENABLE_RETN)) dut (
      .I_CLK    (clk),
      .I_RESET  (rst),
      .I_CLKEN  (clken),
      .I_M1_n   (m1_n),
      .I_MREQ_n (mreq_n),
      .I_IORQ_n (iorq_n),
      .I_RD_n   (rd_n),
      .I_D      (d),
      .O_SPM1   (spm1),
      .O_RETI   (reti),
      .O_RETN   (retn)
   );

   // Clock; the enable changes on the falling edge (1 in 4, or always 1).
   initial begin
      forever begin
         #5 clk = 1'b1;
         #5 clk = 1'b0;
         ph    = (ph + 1) % 4;
         clken = fast ? 1'b1 : (ph == 0);
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Advance to just after the next enabled clock edge.
   task automatic tick();
      int guard;
      guard = 0;
      do begin
         @(posedge clk);
         guard++;
      end while (!clken && guard < 16);
      if (!clken) begin
         $display("FAIL tick: no clock enable within 16 clocks");
         $fatal(1);
      end
      #1;
   endtask

   // ---------------- instruction-level model ----------------
   logic [7:0] mq[$];          // M1 opcodes since last reset/acknowledge
   logic [7:0] m_lat = 8'h00;  // byte on the bus at the last fetch sample
   bit         m_pf  = 1'b0;   // previous enable was a fetch
   bit         m_a, m_f;
   bit         e_spm1 = 1'b0, e_reti = 1'b0, e_retn = 1'b0;

   // Walk the opcode stream as whole instructions; report whether the final
   // byte completes ED 4D (1) or ED 45 (2).
   function automatic int parse_last();
      int i;
      int n;
      int res;
      i   = 0;
      res = 0;
      n   = mq.size();
      while (i < n) begin
         res = 0;
         if (mq[i] == OP_ED) begin
            if (i + 1 < n) begin
               if (mq[i+1] == OP_RETI) res = 1;
               else if (mq[i+1] == OP_RETN && ENABLE_RETN != 0) res = 2;
            end
            i += 2;
         end else if (mq[i] == OP_CB) begin
            i += 2;
         end else if (mq[i] == OP_DD || mq[i] == OP_FD) begin
            if (i + 1 < n && mq[i+1] == OP_CB) i += 2;
            else i += 1;
         end else begin
            i += 1;
         end
      end
      return res;
   endfunction

   always begin
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_lat  = 8'h00;
         m_pf   = 1'b0;
         e_spm1 = 1'b0;
         e_reti = 1'b0;
         e_retn = 1'b0;
      end else if (clken) begin
         m_a    = !m1_n && !iorq_n;
         m_f    = !m1_n && !mreq_n && !rd_n && !m_a;
         e_spm1 = m_a;
         e_reti = 1'b0;
         e_retn = 1'b0;
         if (m_a) begin
            mq.delete();
         end else if (m_pf && !m_f) begin
            mq.push_back(m_lat);
            case (parse_last())
               1:       e_reti = 1'b1;
               2:       e_retn = 1'b1;
               default: ;
            endcase
         end
         if (m_f) m_lat = d;
         m_pf = m_f;
      end
      #1;
      chk("spm1", int'(spm1), int'(e_spm1));
      chk("reti", int'(reti), int'(e_reti));
      chk("retn", int'(retn), int'(e_retn));
   end

   // ---------------- pulse monitor ----------------
   int reti_cnt = 0, retn_cnt = 0, reti_w = 0, reti_wlast = 0;
   bit reti_p = 1'b0, retn_p = 1'b0;

   always begin
      @(posedge clk);
      #1;
      if (reti && !reti_p) reti_cnt++;
      if (retn && !retn_p) retn_cnt++;
      if (reti) begin
         reti_w++;
      end else if (reti_p) begin
         reti_wlast = reti_w;
         reti_w     = 0;
      end
      reti_p = reti;
      retn_p = retn;
   end

   // ---------------- bus-functional Z80 ----------------
   bit end_reti;

   // M1 fetch: 2 + waits samples, I_D = 00 early when stretched, op last.
   task automatic fetch(input logic [7:0] op, input int waits);
      m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
      for (int i = 0; i < 2 + waits; i++) begin
         d = (waits == 0 || i == 1 + waits) ? op : 8'h00;
         tick();
      end
      m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; d = 8'hFF;
      tick();
      end_reti = reti;
      mreq_n = 1'b0;          // refresh: MREQ with M1 high
      tick();
      mreq_n = 1'b1;
      tick();
   endtask

   task automatic mem_read(input logic [7:0] v);
      mreq_n = 1'b0; rd_n = 1'b0; d = v;
      tick();
      tick();
      mreq_n = 1'b1; rd_n = 1'b1; d = 8'hFF;
      tick();
   endtask

   task automatic ack_cycle(output bit s1, output bit s2, output bit s3, output bit s4);
      m1_n = 1'b0; iorq_n = 1'b0;
      tick(); s1 = spm1;
      tick(); s2 = spm1;
      tick(); s3 = spm1;
      m1_n = 1'b1; iorq_n = 1'b1;
      tick(); s4 = spm1;
      tick();
   endtask

   task automatic basic_reti(input string tag, input int width);
      int c0, r0;
      c0 = reti_cnt; r0 = retn_cnt;
      fetch(OP_ED, 0);
      fetch(OP_RETI, 0);
      tick();
      chk({tag, "_reti_at_fetch_end"}, int'(end_reti), 1);
      chk({tag, "_reti_count"}, reti_cnt - c0, 1);
      chk({tag, "_reti_width_clk"}, reti_wlast, width);
      chk({tag, "_retn_count"}, retn_cnt - r0, 0);
   endtask

   task automatic wait_reti(input string tag);
      int c0;
      c0 = reti_cnt;
      fetch(OP_ED, 3);
      fetch(OP_RETI, 0);
      tick();
      chk({tag, "_wait_reti_count"}, reti_cnt - c0, 1);
   endtask

   initial begin
      int c0, r0;
      bit s1, s2, s3, s4;

      // Reset
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_spm1", int'(spm1), 0);
      chk("rst_reti", int'(reti), 0);
      chk("rst_retn", int'(retn), 0);
      rst = 1'b0;
      tick();

      // ED 4D
      basic_reti("t1", 4);

      // CB ED 4D: none; DD ED 4D: one RETI; FD DD ED 45: one RETN
      c0 = reti_cnt;
      fetch(OP_CB, 0); fetch(OP_ED, 0); fetch(OP_RETI, 0); tick();
      chk("t2_cb_ed_4d", reti_cnt - c0, 0);
      c0 = reti_cnt;
      fetch(OP_DD, 0); fetch(OP_ED, 0); fetch(OP_RETI, 0); tick();
      chk("t2_dd_ed_4d", reti_cnt - c0, 1);
      c0 = reti_cnt; r0 = retn_cnt;
      fetch(OP_FD, 0); fetch(OP_DD, 0); fetch(OP_ED, 0); fetch(OP_RETN, 0); tick();
      chk("t2_fd_dd_ed_45_retn", retn_cnt - r0, 1);
      chk("t2_fd_dd_ed_45_reti", reti_cnt - c0, 0);

      // DD CB with ED/4D as non-M1 operand reads, then 00
      c0 = reti_cnt; r0 = retn_cnt;
      fetch(OP_DD, 0); fetch(OP_CB, 0);
      mem_read(OP_ED); mem_read(OP_RETI);
      fetch(8'h00, 0); tick();
      chk("t3_ddcb_reti", reti_cnt - c0, 0);
      chk("t3_ddcb_retn", retn_cnt - r0, 0);
      c0 = reti_cnt;
      fetch(OP_ED, 0); fetch(OP_RETI, 0); tick();
      chk("t3_idle_after", reti_cnt - c0, 1);

      // Acknowledge clears a pending ED
      c0 = reti_cnt;
      fetch(OP_ED, 0);
      ack_cycle(s1, s2, s3, s4);
      chk("t4_spm1_en2", int'(s1), 1);
      chk("t4_spm1_en3", int'(s2), 1);
      chk("t4_spm1_en4", int'(s3), 1);
      chk("t4_spm1_release", int'(s4), 0);
      fetch(OP_RETI, 0); tick();
      chk("t4_no_reti", reti_cnt - c0, 0);

      // Reset between ED and 4D
      c0 = reti_cnt;
      fetch(OP_ED, 0);
      rst = 1'b1;
      tick(); tick();
      chk("t5_rst_spm1", int'(spm1), 0);
      chk("t5_rst_reti", int'(reti), 0);
      chk("t5_rst_retn", int'(retn), 0);
      rst = 1'b0;
      tick();
      fetch(OP_RETI, 0); tick();
      chk("t5_no_reti", reti_cnt - c0, 0);

      // WAIT-stretched ED fetch
      wait_reti("t6");

      // Back-to-back ED 4D ED 4D
      c0 = reti_cnt;
      fetch(OP_ED, 0); fetch(OP_RETI, 0); fetch(OP_ED, 0); fetch(OP_RETI, 0); tick();
      chk("b2b_reti_count", reti_cnt - c0, 2);

      // Same checks with the enable permanently high
      fast = 1'b1;
      repeat (3) @(posedge clk);
      tick();
      basic_reti("fast_t1", 1);
      wait_reti("fast_t6");

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
